// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Optional macro IDEX_FWD_EN enables the EX/MEM and MEM/WB forwarding network.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic [XLEN-1:0]   id_rs_data,
  input  logic [XLEN-1:0]   id_rt_data,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_use_imm,
  input  logic              id_use_shamt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exmem_reg_write,
  input  logic [RA_W-1:0]   exmem_rd_addr,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   memwb_rd_addr,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   selected_A,
  output logic [XLEN-1:0]   selected_B,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_hazard
);

  localparam int unsigned SHAMT_W = 5;

  logic [XLEN-1:0]    ex_rs_data;
  logic [XLEN-1:0]    ex_rt_data;
  logic [RA_W-1:0]    ex_rs_addr;
  logic [RA_W-1:0]    ex_rt_addr;
  logic [XLEN-1:0]    ex_imm;
  logic [SHAMT_W-1:0] ex_shamt;
  logic               ex_use_imm;
  logic               ex_use_shamt;
  logic [XLEN-1:0]    fwd_rs;
  logic [XLEN-1:0]    fwd_rt;

  // True when a writing stage targets a nonzero register equal to s.
  function automatic logic reg_hit(input logic we, input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] s);
    return we && (rd != '0) && (rd == s);
  endfunction

  // Stage register: an invalid ID slot is captured as a bubble, like flush.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !id_valid)) begin
      ex_valid     <= 1'b0;
      alu_ctrl     <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rd_addr   <= '0;
      ex_imm       <= '0;
      ex_shamt     <= '0;
      ex_use_imm   <= 1'b0;
      ex_use_shamt <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= 1'b1;
      alu_ctrl     <= id_alu_ctrl;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_rs_addr   <= id_rs_addr;
      ex_rt_addr   <= id_rt_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_imm       <= id_imm;
      ex_shamt     <= id_shamt;
      ex_use_imm   <= id_use_imm;
      ex_use_shamt <= id_use_shamt;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
    end
  end

`ifdef IDEX_FWD_EN
  // EX/MEM is the youngest producer, so it wins over MEM/WB.
  always_comb begin
    fwd_rs = ex_rs_data;
    fwd_rt = ex_rt_data;
    if (reg_hit(exmem_reg_write, exmem_rd_addr, ex_rs_addr)) begin
      fwd_rs = exmem_result;
    end else if (reg_hit(memwb_reg_write, memwb_rd_addr, ex_rs_addr)) begin
      fwd_rs = memwb_result;
    end
    if (reg_hit(exmem_reg_write, exmem_rd_addr, ex_rt_addr)) begin
      fwd_rt = exmem_result;
    end else if (reg_hit(memwb_reg_write, memwb_rd_addr, ex_rt_addr)) begin
      fwd_rt = memwb_result;
    end
  end

  assign load_use_hazard = ex_valid & ex_mem_read &
                           (reg_hit(1'b1, ex_rd_addr, id_rs_addr) |
                            reg_hit(1'b1, ex_rd_addr, id_rt_addr));
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd_addr, memwb_result,
                        ex_rs_addr, ex_rt_addr};

  assign fwd_rs = ex_rs_data;
  assign fwd_rt = ex_rt_data;

  // Without forwarding, any RAW dependency on EX or EX/MEM must stall ID.
  assign load_use_hazard =
      (ex_valid & ex_mem_read &
       (reg_hit(1'b1, ex_rd_addr, id_rs_addr) | reg_hit(1'b1, ex_rd_addr, id_rt_addr))) |
      (ex_valid &
       (reg_hit(ex_reg_write, ex_rd_addr, id_rs_addr) |
        reg_hit(ex_reg_write, ex_rd_addr, id_rt_addr))) |
      reg_hit(exmem_reg_write, exmem_rd_addr, id_rs_addr) |
      reg_hit(exmem_reg_write, exmem_rd_addr, id_rt_addr);
`endif

  // ALU shifts B by A, so the shift amount goes on A.
  assign selected_A    = ex_use_shamt ? XLEN'(ex_shamt) : fwd_rs;
  assign selected_B    = ex_use_imm ? ex_imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow IDEX_FWD_EN when defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic        id_use_imm, id_use_shamt, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [3:0]  alu_ctrl;
  logic [31:0] selected_A, selected_B, ex_store_data;
  logic [4:0]  ex_rd_addr;

  int tests_run = 0;
  int tests_failed = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_ctrl(id_alu_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_use_imm(id_use_imm),
    .id_use_shamt(id_use_shamt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_ctrl(alu_ctrl), .selected_A(selected_A),
    .selected_B(selected_B), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 1'b0; id_alu_ctrl = '0; id_rs_data = '0; id_rt_data = '0;
    id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0; id_imm = '0; id_shamt = '0;
    id_use_imm = 1'b0; id_use_shamt = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
  endtask

  task automatic fwd_idle();
    exmem_reg_write = 1'b0; exmem_rd_addr = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd_addr = '0; memwb_result = '0;
  endtask

  task automatic id_alu(input logic [3:0] ctrl, input logic [4:0] rs, input logic [31:0] rs_d,
                        input logic [4:0] rt, input logic [31:0] rt_d, input logic [4:0] rd);
    id_idle();
    id_valid = 1'b1; id_alu_ctrl = ctrl; id_reg_write = 1'b1;
    id_rs_addr = rs; id_rs_data = rs_d; id_rt_addr = rt; id_rt_data = rt_d; id_rd_addr = rd;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_idle();
    fwd_idle();
    step();
    step();

    // Reset released with an empty ID slot
    rst = 1'b0;
    step();
    check("reset_valid", 32'(ex_valid), 32'd0);
    check("reset_regwr", 32'(ex_reg_write), 32'd0);
    check("reset_ctrl", 32'(alu_ctrl), 32'd0);
    check("reset_selA", selected_A, 32'd0);
    check("reset_selB", selected_B, 32'd0);
    check("reset_hazard", 32'(load_use_hazard), 32'd0);

    // Plain ADD, no forwarding matches
    id_alu(4'd0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd9);
    step();
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_selA", selected_A, 32'd5);
    check("add_selB", selected_B, 32'd7);
    check("add_rd", 32'(ex_rd_addr), 32'd9);
    check("add_regwr", 32'(ex_reg_write), 32'd1);

    // rs=3 matched by both EX/MEM and MEM/WB
    id_alu(4'd1, 5'd3, 32'h55, 5'd4, 32'h66, 5'd10);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd3; memwb_result = 32'h22;
    step();
`ifdef IDEX_FWD_EN
    check("fwd_both_selA", selected_A, 32'h11);
    check("fwd_hazard_none", 32'(load_use_hazard), 32'd0);
`else
    check("nofwd_both_selA", selected_A, 32'h55);
    check("nofwd_raw_hazard", 32'(load_use_hazard), 32'd1);
`endif
    check("fwd_selB_plain", selected_B, 32'h66);
    exmem_reg_write = 1'b0;
    #1;
`ifdef IDEX_FWD_EN
    check("fwd_memwb_selA", selected_A, 32'h22);
`else
    check("nofwd_memwb_selA", selected_A, 32'h55);
`endif
    memwb_rd_addr = 5'd4;
    #1;
`ifdef IDEX_FWD_EN
    check("fwd_memwb_selB", selected_B, 32'h22);
`else
    check("nofwd_memwb_selB", selected_B, 32'h66);
`endif

    // Register 0 is never forwarded
    id_alu(4'd0, 5'd0, 32'h33, 5'd0, 32'h44, 5'd10);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_result = 32'h22;
    step();
    check("r0_selA", selected_A, 32'h33);
    check("r0_selB", selected_B, 32'h44);
    fwd_idle();

    // Shift: amount on A, value on B
    id_alu(4'd8, 5'd0, 32'h99, 5'd5, 32'd1, 5'd11);
    id_use_shamt = 1'b1; id_shamt = 5'd4;
    step();
    check("shift_ctrl", 32'(alu_ctrl), 32'd8);
    check("shift_selA", selected_A, 32'd4);
    check("shift_selB", selected_B, 32'd1);

    // Immediate on B; store data still carries rt (forwarded from MEM/WB)
    id_alu(4'd0, 5'd6, 32'h99, 5'd5, 32'h77, 5'd12);
    id_use_imm = 1'b1; id_imm = 32'hFFFF_FFF0;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd5; memwb_result = 32'hAB;
    step();
    check("imm_selA", selected_A, 32'h99);
    check("imm_selB", selected_B, 32'hFFFF_FFF0);
`ifdef IDEX_FWD_EN
    check("imm_store", ex_store_data, 32'hAB);
`else
    check("imm_store", ex_store_data, 32'h77);
`endif
    fwd_idle();

    // Load into r8, then a consumer of r8 in ID
    id_alu(4'd0, 5'd1, 32'h0, 5'd2, 32'h0, 5'd8);
    id_mem_read = 1'b1;
    step();
    check("load_memrd", 32'(ex_mem_read), 32'd1);
    id_alu(4'd0, 5'd8, 32'h1, 5'd0, 32'h0, 5'd13);
    #1;
    check("loaduse_hazard", 32'(load_use_hazard), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_regwr", 32'(ex_reg_write), 32'd0);
    check("flush_memrd", 32'(ex_mem_read), 32'd0);
    check("flush_hazard_clear", 32'(load_use_hazard), 32'd0);
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd8; memwb_result = 32'hCAFE;
    step();
`ifdef IDEX_FWD_EN
    check("loaduse_fwd_selA", selected_A, 32'hCAFE);
`else
    check("loaduse_nofwd_selA", selected_A, 32'h1);
`endif
    fwd_idle();

    // Stall holds everything for two cycles while ID changes
    id_alu(4'd2, 5'd1, 32'h10, 5'd2, 32'h20, 5'd14);
    step();
    stall = 1'b1;
    id_alu(4'd5, 5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 5'd15);
    step();
    id_rs_data = 32'h1234;
    step();
    check("stall_ctrl", 32'(alu_ctrl), 32'd2);
    check("stall_selA", selected_A, 32'h10);
    check("stall_selB", selected_B, 32'h20);
    check("stall_rd", 32'(ex_rd_addr), 32'd14);
    check("stall_valid", 32'(ex_valid), 32'd1);

    // Flush wins over stall
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("stallflush_valid", 32'(ex_valid), 32'd0);
    check("stallflush_ctrl", 32'(alu_ctrl), 32'd0);
    check("stallflush_selA", selected_A, 32'd0);

    // Reset wins over stall
    stall = 1'b0;
    id_alu(4'd3, 5'd1, 32'h50, 5'd2, 32'h60, 5'd16);
    step();
    check("pre_rst_selB", selected_B, 32'h60);
    stall = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    check("rst_stall_valid", 32'(ex_valid), 32'd0);
    check("rst_stall_rd", 32'(ex_rd_addr), 32'd0);
    check("rst_stall_selB", selected_B, 32'd0);
    check("rst_stall_regwr", 32'(ex_reg_write), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with an integrated operand-forwarding network, directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID each cycle.
- Supports stall (hold) and flush (bubble insertion).
- Drives the ALU's ctrl, selected_A and selected_B, resolving RAW hazards from EX/MEM and MEM/WB.
- Flags load-use hazards so the hazard controller can stall the front end.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width
CTRL_W, 4, ALU control width (codes 0-10 in use)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
stall  input  1  hold all stage registers
flush  input  1  load a bubble
id_valid  input  1  ID holds a real instruction
id_alu_ctrl  input  CTRL_W  ALU operation code
id_rs_data, id_rt_data  input  XLEN  register-file read data
id_rs_addr, id_rt_addr, id_rd_addr  input  RA_W  source/destination register numbers
id_imm  input  XLEN  immediate, already extended
id_shamt  input  5  shift amount
id_use_imm  input  1  B operand = immediate
id_use_shamt  input  1  A operand = shamt
id_reg_write, id_mem_read, id_mem_write  input  1  downstream controls
exmem_reg_write  input  1  EX/MEM writes a register
exmem_rd_addr  input  RA_W  EX/MEM destination register
exmem_result  input  XLEN  EX/MEM result
memwb_reg_write  input  1  MEM/WB writes a register
memwb_rd_addr  input  RA_W  MEM/WB destination register
memwb_result  input  XLEN  MEM/WB write-back data
ex_valid  output  1  EX holds a real instruction
alu_ctrl  output  CTRL_W  to ALU ctrl
selected_A, selected_B  output  XLEN  to ALU operands
ex_store_data  output  XLEN  forwarded rt value for stores
ex_rd_addr  output  RA_W  destination register
ex_reg_write, ex_mem_read, ex_mem_write  output  1  registered controls
load_use_hazard  output  1  combinational; ID must stall one cycle

Behaviour:
- Clock and reset: single clk domain. rst is synchronous and active-high.
- Reset: every stage register is cleared to 0. Result: ex_valid=0, alu_ctrl=0, all controls 0, ex_rd_addr=0, selected_A=selected_B=ex_store_data=0 (absent forwarding), load_use_hazard=0.
- Per-edge priority: rst > flush > stall > load.
  - flush (including flush with stall in the same cycle): all fields cleared as for reset, producing a bubble.
  - stall alone: all fields hold.
  - load: all id_* fields captured. If id_valid=0, a bubble is captured instead (controls forced to 0).
- Latency: one cycle from ID inputs to EX outputs.
- Forwarding (combinational, EX side), per source register s in {rs, rt}:
  - EX/MEM first: if exmem_reg_write and exmem_rd_addr != 0 and exmem_rd_addr == s, use exmem_result.
  - Otherwise MEM/WB: if memwb_reg_write and memwb_rd_addr != 0 and memwb_rd_addr == s, use memwb_result.
  - Otherwise use the registered data.
  - Register 0 is never forwarded.
  - When both stages match, EX/MEM wins (youngest producer).
- Operand select:
  - selected_A = ex_use_shamt ? {27'b0, ex_shamt} : fwd_rs.
  - selected_B = ex_use_imm ? ex_imm : fwd_rt.
  - ex_store_data = fwd_rt regardless of use_imm.
- Shift convention: the ALU shifts B by A, so shifts place the shift amount on A and the shifted value on B.
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr != 0) & ((ex_rd_addr == id_rs_addr) | (ex_rd_addr == id_rt_addr)).
  - The hazard controller responds by stalling PC/IF-ID and asserting flush here for one cycle.
  - The following cycle the MEM/WB forward supplies the loaded value.
- Stall while forwarding: registered data stays frozen, so forwarded values track whatever the downstream stages currently present.

Optional Feature:
Macro IDEX_FWD_EN.
- Defined: forwarding network exactly as above.
- Undefined: fwd_rs and fwd_rt are the registered data only. load_use_hazard widens to any RAW hazard: it also asserts when id_rs_addr or id_rt_addr (nonzero) matches ex_rd_addr with ex_reg_write, or exmem_rd_addr with exmem_reg_write. The ports are unchanged; the exmem/memwb result inputs are ignored.

Test Plan:
- Reset then release with id_valid=0 → ex_valid=0, ex_reg_write=0, alu_ctrl=0, selected_A=selected_B=0.
- Load ADD with rs_data=5, rt_data=7, no matches → next cycle alu_ctrl=0, selected_A=5, selected_B=7.
- ex_rs_addr=3, exmem_rd_addr=3 (write, result 0x11), memwb_rd_addr=3 (write, result 0x22) → selected_A=0x11. Drop the exmem match → selected_A=0x22. Set exmem_rd_addr=0 with ex_rs_addr=0 → registered value.
- Shift: id_use_shamt=1, shamt=4, rt_data=1, ctrl=8 → selected_A=4, selected_B=1. id_use_imm=1, imm=0xFFFFFFF0 → selected_B=0xFFFFFFF0 and ex_store_data=forwarded rt.
- EX holds load (mem_read=1, rd=8); ID presents rs=8 → load_use_hazard=1. Assert flush → bubble (ex_valid=0, controls 0). Next cycle memwb forward supplies the loaded value.
- stall=1 for 2 cycles with changing id_* → outputs unchanged. stall=1 and flush=1 together → bubble. rst mid-stall → all fields cleared next edge.
